bus_arb: RTL
============

BUS_ARB -- requirements
Module: bus_arb

Interface
REQ-001 SHALL have parameter N_MASTERS, default 3, number of requesting masters (2..8).
REQ-002 SHALL have parameter ADR_W, default 32, address width.
REQ-003 SHALL have parameter DATA_W, default 32, data width; byte-enable width WB = DATA_W/8.
REQ-004 SHALL have parameter RD_LAT, default 1, slave read latency in cycles (1..4).
REQ-005 SHALL have port clk  in  1  single clock.
REQ-006 SHALL have port n_reset  in  1  reset, asynchronous, active-low.
REQ-007 SHALL have port en  in  1  grant enable; low blocks new grants.
REQ-008 SHALL have port m_valid  in  N_MASTERS  per-master request.
REQ-009 SHALL have port m_adr  in  N_MASTERS*ADR_W  packed addresses, master i at slice i.
REQ-010 SHALL have port m_wren  in  N_MASTERS*WB  packed byte write enables; all-zero means read.
REQ-011 SHALL have port m_di  in  N_MASTERS*DATA_W  packed write data.
REQ-012 SHALL have port m_ready  out  N_MASTERS  one-cycle completion pulse; it is both command accept and response valid.
REQ-013 SHALL have port m_do  out  DATA_W  registered read data, shared by all masters.
REQ-014 SHALL have ports s_op (out, 1), s_adr (out, ADR_W), s_wren (out, WB) and s_di (out, DATA_W), forming the slave command.
REQ-015 SHALL have port s_do  in  DATA_W  slave read data, OR-bus, valid RD_LAT cycles after s_op.
REQ-016 SHALL have ports busy (out, 1) and grant_idx (out, clog2(N_MASTERS)) for debug.

Function
REQ-017 SHALL implement FSM states IDLE, ISSUE, WAIT and RESP.
REQ-018 IDLE: if en and any m_valid, latch the winner into grant_idx and go to ISSUE; otherwise stay in IDLE.
REQ-019 ISSUE: drive s_op=1 for exactly one cycle with the granted master's adr/wren/di taken from registered copies, then go to WAIT.
REQ-020 WAIT: count RD_LAT cycles from the ISSUE edge; on the last count, latch s_do into m_do and go to RESP.
REQ-021 RESP: assert m_ready[grant_idx] for one cycle, then go to IDLE.
REQ-022 Latency: m_valid sampled in IDLE at edge 0 gives m_ready high in cycle RD_LAT+2; the next grant is sampled no earlier than the edge ending RESP.
REQ-023 Outside ISSUE, s_op=0, s_wren=0, s_adr=0 and s_di=0.
REQ-024 Writes follow identical timing; m_do is still latched from s_do, and its value is don't-care.
REQ-025 Masters SHALL hold m_valid, m_adr, m_wren and m_di stable until m_ready; a master that drops m_valid mid-transaction still receives its m_ready pulse, and no abort occurs.
REQ-026 A master's m_valid still high during its own RESP cycle SHALL NOT be re-granted in that cycle.
REQ-027 en low during ISSUE, WAIT or RESP lets the in-flight transaction complete; only the next grant is blocked.
REQ-028 busy=1 in ISSUE, WAIT and RESP, and 0 in IDLE.
REQ-029 m_ready SHALL be one-hot or zero at all times.

Reset
REQ-030 n_reset low SHALL asynchronously force state IDLE, m_ready=0, m_do=0, s_op=0, s_wren=0, busy=0, grant_idx=0, and the round-robin pointer to N_MASTERS-1.
REQ-031 Reset mid-transaction SHALL discard that transaction; no m_ready pulse is issued for it after release.

Configuration
REQ-032 With macro BUS_ARB_RR_EN defined, arbitration SHALL be round-robin: the search starts at last_grant+1 modulo N_MASTERS, and the pointer updates on each grant.
REQ-033 Without BUS_ARB_RR_EN, arbitration SHALL be fixed priority with the lowest index winning, and no pointer register is present.

Structure
REQ-034 Package bus_arb_pkg SHALL hold the FSM state typedef and the RD_LAT counter width constant.
REQ-035 The winner selection SHALL be a combinational sub-module, arb_pick, with inputs req vector, pointer and rr-mode, and outputs winner index and found flag.

Verification
REQ-036 Single read: N=3, RD_LAT=1, master 1 reads 0x00000010 while the slave returns 0xDEADBEEF -> s_op pulses in cycle 1, m_ready=3'b010 in cycle 3, m_do=0xDEADBEEF.
REQ-037 Write: master 0 issues wren=4'b0011, adr 0x10004, di 0x12345678 -> s_wren=4'b0011 and s_di=0x12345678 during the s_op cycle, m_ready[0] pulses once.
REQ-038 Contention with RR: all three masters hold valid -> grants follow the order 0,1,2,0 on four consecutive transactions; with the macro undefined, master 0 receives every grant.
REQ-039 Enable gating: en=0 with master 2 requesting -> no s_op for 10 cycles; en=1 -> grant within 1 cycle; en dropped during WAIT -> the current m_ready still pulses.
REQ-040 Reset mid-WAIT with RD_LAT=3 -> outputs go to 0 immediately, no m_ready after release, and the first post-reset grant goes to master 0.
REQ-041 Latency sweep: RD_LAT=1..4 -> m_ready in cycle RD_LAT+2 each time, and m_ready is never multi-hot.

Source files
------------

// File: rtl/bus_arb_pkg.sv
// Shared types and constants for the bus_arb shared-slave arbiter.
// State encoding and the read-latency counter width live here so every file agrees.
package bus_arb_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } state_t;

    localparam int LAT_MAX = 4;
    localparam int CNT_W   = $clog2(LAT_MAX + 1);

endpackage

// File: rtl/bus_arb_if.sv
// Bundle of the per-master request/response lines and the single slave command port.
// 'master' and 'slave' are the two outside views; 'arb' is the arbiter's own view.
interface bus_arb_if #(
    parameter int N_MASTERS = 3,
    parameter int ADR_W     = 32,
    parameter int DATA_W    = 32
);
    localparam int WB = DATA_W / 8;

    logic [N_MASTERS-1:0]        m_valid;
    logic [N_MASTERS*ADR_W-1:0]  m_adr;
    logic [N_MASTERS*WB-1:0]     m_wren;
    logic [N_MASTERS*DATA_W-1:0] m_di;
    logic [N_MASTERS-1:0]        m_ready;
    logic [DATA_W-1:0]           m_do;

    logic                        s_op;
    logic [ADR_W-1:0]            s_adr;
    logic [WB-1:0]               s_wren;
    logic [DATA_W-1:0]           s_di;
    logic [DATA_W-1:0]           s_do;

    modport master (
        output m_valid, m_adr, m_wren, m_di,
        input  m_ready, m_do
    );

    modport slave (
        input  s_op, s_adr, s_wren, s_di,
        output s_do
    );

    modport arb (
        input  m_valid, m_adr, m_wren, m_di, s_do,
        output m_ready, m_do, s_op, s_adr, s_wren, s_di
    );

endinterface

// File: rtl/bus_arb_pick.sv
// Combinational winner selection: lowest index first, or round-robin starting after ptr.
module arb_pick #(
    parameter int N     = 3,
    parameter int IDX_W = 2
) (
    input  logic [N-1:0]     req,
    input  logic [IDX_W-1:0] ptr,
    input  logic             rr_mode,
    output logic [IDX_W-1:0] winner,
    output logic             found
);

    logic [IDX_W-1:0] cand;

    // Walk the candidates in priority order and keep the first one requesting.
    always_comb begin
        winner = '0;
        found  = 1'b0;
        cand   = '0;
        for (int i = 0; i < N; i++) begin
            if (rr_mode) begin
                cand = IDX_W'((int'(ptr) + 1 + i) % N);
            end else begin
                cand = IDX_W'(i);
            end
            if (!found && req[cand]) begin
                found  = 1'b1;
                winner = cand;
            end
        end
    end

endmodule

// File: rtl/bus_arb.sv
// N-master to single-slave arbiter: one transaction at a time, IDLE->ISSUE->WAIT->RESP.
// Define BUS_ARB_RR_EN for round-robin arbitration; otherwise fixed lowest-index priority.
module bus_arb
    import bus_arb_pkg::*;
#(
    parameter int N_MASTERS = 3,
    parameter int ADR_W     = 32,
    parameter int DATA_W    = 32,
    parameter int RD_LAT    = 1
) (
    input  logic                         clk,
    input  logic                         n_reset,
    input  logic                         en,
    bus_arb_if.arb                       bus,
    output logic                         busy,
    output logic [$clog2(N_MASTERS)-1:0] grant_idx
);

    localparam int WB    = DATA_W / 8;
    localparam int IDX_W = $clog2(N_MASTERS);

    state_t            state_q;
    state_t            state_d;
    logic [IDX_W-1:0]  grant_q;
    logic [IDX_W-1:0]  winner;
    logic [IDX_W-1:0]  ptr;
    logic              found;
    logic              rr_mode;
    logic              grant_now;
    logic              last_wait;
    logic [CNT_W-1:0]  cnt_q;
    logic [ADR_W-1:0]  adr_q;
    logic [WB-1:0]     wren_q;
    logic [DATA_W-1:0] di_q;
    logic [DATA_W-1:0] do_q;

`ifdef BUS_ARB_RR_EN
    logic [IDX_W-1:0] ptr_q;

    // Pointer remembers the last winner so the next search starts just after it.
    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            ptr_q <= IDX_W'(N_MASTERS - 1);
        end else if (grant_now) begin
            ptr_q <= winner;
        end
    end

    assign ptr     = ptr_q;
    assign rr_mode = 1'b1;
`else
    assign ptr     = '0;
    assign rr_mode = 1'b0;
`endif

    arb_pick #(
        .N     (N_MASTERS),
        .IDX_W (IDX_W)
    ) u_pick (
        .req     (bus.m_valid),
        .ptr     (ptr),
        .rr_mode (rr_mode),
        .winner  (winner),
        .found   (found)
    );

    assign grant_now = (state_q == IDLE) && en && found;
    assign last_wait = (state_q == WAIT) && (cnt_q == CNT_W'(RD_LAT));

    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            state_q <= IDLE;
            grant_q <= '0;
            cnt_q   <= '0;
            adr_q   <= '0;
            wren_q  <= '0;
            di_q    <= '0;
            do_q    <= '0;
        end else begin
            state_q <= state_d;
            // Command is copied at grant so the slave sees a stable value even if the master lets go.
            if (grant_now) begin
                grant_q <= winner;
                adr_q   <= bus.m_adr[int'(winner)*ADR_W +: ADR_W];
                wren_q  <= bus.m_wren[int'(winner)*WB +: WB];
                di_q    <= bus.m_di[int'(winner)*DATA_W +: DATA_W];
            end
            if (state_q == ISSUE) begin
                cnt_q <= CNT_W'(1);
            end else if ((state_q == WAIT) && !last_wait) begin
                cnt_q <= cnt_q + 1'b1;
            end
            if (last_wait) begin
                do_q <= bus.s_do;
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        bus.s_op    = 1'b0;
        bus.s_adr   = '0;
        bus.s_wren  = '0;
        bus.s_di    = '0;
        bus.m_ready = '0;
        case (state_q)
            IDLE: begin
                if (grant_now) begin
                    state_d = ISSUE;
                end
            end
            ISSUE: begin
                bus.s_op   = 1'b1;
                bus.s_adr  = adr_q;
                bus.s_wren = wren_q;
                bus.s_di   = di_q;
                state_d    = WAIT;
            end
            WAIT: begin
                if (last_wait) begin
                    state_d = RESP;
                end
            end
            RESP: begin
                bus.m_ready[grant_q] = 1'b1;
                state_d              = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign bus.m_do  = do_q;
    assign busy      = (state_q != IDLE);
    assign grant_idx = grant_q;

endmodule
